shake256_arbiter: RTL and testbench

Sequencer that shares one `SHAKE256` core between two requesters. It arbitrates round-robin, latches the winner's 1088-bit rate block and length, and restarts the core through its reset input. It then waits for `squeezed`, captures the 1088-bit output and returns it to the winner over a valid/ready response channel. It sits between the board-level wrapper/test logic and the single `SHAKE256` instance, and enforces a length check and a watchdog timeout.

---
 rtl/shake256_arbiter_pkg.sv | 27 ++
 rtl/shake256_arbiter_if.sv | 37 +++
 rtl/shake256_rr_arb2.sv | 30 +++
 rtl/shake256_arbiter.sv | 127 ++++++++++++
 tb/tb_shake256_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shake256_arbiter_pkg.sv
// shake256_arbiter shared types
// Widths, FSM encoding and the latched request bundle
package shake256_pkg;

  localparam int unsigned RATE_BITS = 1088;
  localparam int unsigned LEN_W     = 11;
  localparam int unsigned CNT_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RESP
  } arb_state_t;

  typedef struct packed {
    logic [RATE_BITS-1:0] msg;
    logic [LEN_W-1:0]     len;
  } shake_req_t;

  function automatic logic [1:0] onehot2(
    input logic idx
  );
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shake256_arbiter_if.sv
// Requester-side request/response channels
// master = requesters, slave = arbiter
interface shake256_arbiter_if;
  import shake256_pkg::*;

  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [1:0][RATE_BITS-1:0] req_message;
  logic [1:0][LEN_W-1:0]     req_length;
  logic [1:0]                rsp_valid;
  logic [1:0]                rsp_ready;
  logic [RATE_BITS-1:0]      rsp_hash;
  logic                      rsp_error;

  modport master (
    output req_valid,
    output req_message,
    output req_length,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_hash,
    input  rsp_error
  );

  modport slave (
    input  req_valid,
    input  req_message,
    input  req_length,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_hash,
    output rsp_error
  );

endinterface

// File: rtl/shake256_rr_arb2.sv
// Two-way round-robin grant
// Combinational grant, last pointer advances on transfer
module shake256_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  input  logic       fire_i,
  output logic [1:0] grant_o,
  output logic       gidx_o
);

  logic last_q;

  // Tie goes to the requester that did not win last
  assign gidx_o = valid_i[1] & (~valid_i[0] | ~last_q);

  assign grant_o = (en_i && (valid_i != 2'b00))
                 ? (gidx_o ? 2'b10 : 2'b01)
                 : 2'b00;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (fire_i) begin
      last_q <= gidx_o;
    end
  end

endmodule

// File: rtl/shake256_arbiter.sv
// Shares one SHAKE256 core between two requesters
// Length check, watchdog, valid/ready response
module shake256_arbiter
  import shake256_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned LEN_MAX        = 1087
) (
  input  logic                 clock,
  input  logic                 reset,
  shake256_arbiter_if.slave    bus,
  output logic                 core_reset,
  output logic [RATE_BITS-1:0] core_message,
  output logic [LEN_W-1:0]     core_length,
  input  logic                 core_squeezed,
  input  logic [RATE_BITS-1:0] core_hash
);

  localparam logic [LEN_W-1:0] LEN_LIM =
    LEN_W'(LEN_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_q, state_d;
  shake_req_t           job_q, job_d;
  logic                 owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RATE_BITS-1:0] hash_q, hash_d;
  logic                 err_q, err_d;

  logic       idle;
  logic       fire;
  logic       gidx;
  logic [1:0] grant;

  assign idle = (state_q == ST_IDLE);

  shake256_rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .valid_i (bus.req_valid),
    .en_i    (idle),
    .fire_i  (fire),
    .grant_o (grant),
    .gidx_o  (gidx)
  );

  assign bus.req_ready = grant;
  assign fire = |(bus.req_valid & grant);

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    hash_d  = hash_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          job_d.msg = bus.req_message[gidx];
          job_d.len = bus.req_length[gidx];
          owner_d   = gidx;
          if (bus.req_length[gidx] > LEN_LIM) begin
            hash_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A squeeze on the last allowed cycle still wins
        if (core_squeezed) begin
          hash_d  = core_hash;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          hash_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      job_q   <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      hash_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_RESP)
                       ? onehot2(owner_q)
                       : 2'b00;
  assign bus.rsp_hash  = hash_q;
  assign bus.rsp_error = err_q;

  assign core_reset   = (state_q != ST_RUN);
  assign core_message = job_q.msg;
  assign core_length  = job_q.len;

endmodule

// File: tb/tb_shake256_arbiter.sv
// Random + directed bench for shake256_arbiter
// Job-level reference model and a per-cycle compare
module tb_shake256_arbiter;
  import shake256_pkg::*;

  localparam int TO   = 8;
  localparam int LMAX = 1087;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  shake256_arbiter_if bus();

  logic                 core_reset;
  logic [RATE_BITS-1:0] core_message;
  logic [LEN_W-1:0]     core_length;
  logic                 core_squeezed;
  logic [RATE_BITS-1:0] core_hash;

  shake256_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .LEN_MAX        (LMAX)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .core_reset    (core_reset),
    .core_message  (core_message),
    .core_length   (core_length),
    .core_squeezed (core_squeezed),
    .core_hash     (core_hash)
  );

  // Core stand-in: squeezes on RUN cycle index sq_delay
  int run_cnt;
  int sq_delay;
  always_ff @(posedge clock)
    run_cnt <= core_reset ? 0 : run_cnt + 1;
  assign core_squeezed =
    !core_reset && (run_cnt == sq_delay);

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  bit                   m_busy, m_resp;
  int                   m_last, m_owner, m_acc;
  int                   cyc = 0;
  logic [RATE_BITS-1:0] m_msg, m_hash;
  logic [LEN_W-1:0]     m_len;
  logic                 m_err;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s @%0d: got %0h want %0h",
                 nm, cyc, got, exp);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [RATE_BITS-1:0] got,
                      input logic [RATE_BITS-1:0] exp);
    ntot++;
    if (got === exp) npass++;
    else begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s @%0d: got ..%0h want ..%0h",
                 nm, cyc, got[63:0], exp[63:0]);
    end
  endtask

  function automatic int grant_of(input logic [1:0] v,
                                  input int last);
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [RATE_BITS-1:0] rnd_blk();
    logic [RATE_BITS-1:0] r;
    for (int i = 0; i < RATE_BITS / 32; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_last = 1; m_owner = 0;
    m_acc = 0; m_msg = '0; m_len = '0;
    m_hash = '0; m_err = 1'b0;
  endtask

  // Advance the job model across the coming edge
  task automatic model_step();
    logic [1:0] v;
    int g, k;
    v = bus.req_valid;
    if (reset) model_reset();
    else if (!m_busy && !m_resp) begin
      if (v != 2'b00) begin
        g = grant_of(v, m_last);
        m_last = g; m_owner = g; m_acc = cyc;
        m_msg = bus.req_message[g];
        m_len = bus.req_length[g];
        if (int'(m_len) > LMAX) begin
          m_resp = 1; m_err = 1'b1; m_hash = '0;
        end else m_busy = 1;
      end
    end else if (m_busy) begin
      if (cyc >= m_acc + 2) begin
        k = cyc - m_acc - 2;
        if (core_squeezed) begin
          m_busy = 0; m_resp = 1;
          m_err = 1'b0; m_hash = core_hash;
        end else if (k + 1 == TO) begin
          m_busy = 0; m_resp = 1;
          m_err = 1'b1; m_hash = '0;
        end
      end
    end else if (bus.rsp_ready[m_owner]) m_resp = 0;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
    model_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] er;
    forever begin
      @(negedge clock);
      if (!m_busy && !m_resp && bus.req_valid != 2'b00)
        er = oh(grant_of(bus.req_valid, m_last));
      else er = 2'b00;
      chk("req_ready", bus.req_ready, er);
      chk("rsp_valid", bus.rsp_valid,
          m_resp ? oh(m_owner) : 2'b00);
      chk("rsp_error", bus.rsp_error, m_err);
      chkw("rsp_hash", bus.rsp_hash, m_hash);
      chk("core_reset", core_reset,
          (m_busy && cyc >= m_acc + 2) ? 0 : 1);
      chk("core_length", core_length, m_len);
      chkw("core_message", core_message, m_msg);
    end
  end

  task automatic wait_acc(output int g, output int t0);
    int n = 0;
    #1;
    while ((bus.req_ready & bus.req_valid) == 2'b00
           && n < 40) begin
      tick(); n++;
    end
    chk("accept_in_time", n < 40, 1);
    chk("req_ready_not_both", bus.req_ready == 2'b11, 0);
    g = bus.req_ready[1] ? 1 : 0;
    t0 = cyc;
  endtask

  task automatic wait_rsp(input int t0, output int lat);
    int n = 0;
    while (bus.rsp_valid == 2'b00 && n < 60) begin
      tick(); n++;
    end
    chk("rsp_in_time", n < 60, 1);
    lat = cyc - t0;
  endtask

  task automatic do_job(input logic [1:0] v,
                        input int dly, input bit clr,
                        output int g, output int lat,
                        output logic err,
                        output logic [RATE_BITS-1:0] h,
                        output logic crst);
    int t0;
    bus.req_valid = v;
    sq_delay = dly;
    wait_acc(g, t0);
    tick();
    if (clr) bus.req_valid = 2'b00;
    wait_rsp(t0, lat);
    err = bus.rsp_error;
    h = bus.rsp_hash;
    crst = core_reset;
    chk("rsp_owner", bus.rsp_valid, oh(g));
    bus.rsp_ready = oh(g);
    tick();
    bus.rsp_ready = 2'b00;
  endtask

  initial begin
    int g, g2, lat, t0;
    logic e, cr, r;
    logic [RATE_BITS-1:0] h, hv;
    logic [RATE_BITS-1:0] a5;
    logic [1:0] pend, acc;
    a5 = {136{8'hA5}};
    model_reset();
    reset = 1'b1;
    bus.req_valid = '0; bus.rsp_ready = '0;
    bus.req_message = '0; bus.req_length = '0;
    core_hash = '0; sq_delay = 1000;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chkw("rst_rsp_hash", bus.rsp_hash, '0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_length", core_length, 0);
    chk("rst_req_ready", bus.req_ready, 0);

    // Ties after reset alternate 0,1,0
    bus.req_length[0] = 11'd100;
    bus.req_length[1] = 11'd200;
    bus.req_message[1] = rnd_blk();
    core_hash = rnd_blk();
    do_job(2'b11, 3, 0, g, lat, e, h, cr);
    chk("tie_grant0", g, 0);
    do_job(2'b11, 3, 0, g, lat, e, h, cr);
    chk("tie_grant1", g, 1);
    do_job(2'b11, 3, 0, g, lat, e, h, cr);
    chk("tie_grant2", g, 0);
    bus.req_valid = 2'b00;
    tick();

    // Single request, squeeze 5 RUN cycles in
    bus.req_message[0] = '0;
    bus.req_length[0] = '0;
    core_hash = a5;
    do_job(2'b01, 5, 1, g, lat, e, h, cr);
    chk("single_grant", g, 0);
    chk("single_latency", lat, 8);
    chk("single_error", e, 0);
    chkw("single_hash", h, a5);
    chk("single_core_reset", cr, 1);

    // Over-length request is rejected next cycle
    bus.req_length[1] = 11'd1088;
    do_job(2'b10, 0, 1, g, lat, e, h, cr);
    chk("rej_grant", g, 1);
    chk("rej_latency", lat, 1);
    chk("rej_error", e, 1);
    chkw("rej_hash", h, '0);
    chk("rej_core_reset", cr, 1);

    // Watchdog, then squeeze on last allowed cycle
    core_hash = rnd_blk();
    do_job(2'b01, 1000, 1, g, lat, e, h, cr);
    chk("to_latency", lat, TO + 2);
    chk("to_error", e, 1);
    chkw("to_hash", h, '0);
    hv = rnd_blk();
    core_hash = hv;
    do_job(2'b01, TO - 1, 1, g, lat, e, h, cr);
    chk("edge_latency", lat, TO + 2);
    chk("edge_error", e, 0);
    chkw("edge_hash", h, hv);

    // Backpressure; non-owner ready is ignored
    bus.req_valid = 2'b01;
    sq_delay = 2;
    wait_acc(g, t0);
    tick();
    bus.req_valid = 2'b11;
    wait_rsp(t0, lat);
    h = bus.rsp_hash;
    bus.rsp_ready = 2'b10;
    repeat (10) begin
      tick();
      chkw("bp_hash_stable", bus.rsp_hash, h);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_rsp_valid", bus.rsp_valid, 2'b01);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;

    // Reset mid-RUN drops the job
    bus.req_message[1] = rnd_blk();
    bus.req_length[1] = 11'd500;
    bus.req_valid = 2'b10;
    sq_delay = 1000;
    wait_acc(g, t0);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("run_core_reset", core_reset, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_core_reset", core_reset, 1);
    chkw("mr_core_message", core_message, '0);
    chk("mr_core_length", core_length, 0);
    chkw("mr_rsp_hash", bus.rsp_hash, '0);
    chk("mr_rsp_error", bus.rsp_error, 0);
    chk("mr_req_ready", bus.req_ready, 0);
    bus.req_valid = 2'b11;
    wait_acc(g2, t0);
    chk("mr_next_grant", g2, 0);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(t0, lat);
    chk("mr_job_timeout", bus.rsp_error, 1);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;

    // Random traffic; requesters hold until accepted
    pend = 2'b00;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          bus.req_message[i] = rnd_blk();
          if ($urandom_range(0, 5) == 0)
            bus.req_length[i] =
              LEN_W'($urandom_range(1088, 2047));
          else
            bus.req_length[i] =
              LEN_W'($urandom_range(0, 1087));
        end
      end
      bus.req_valid = pend;
      bus.rsp_ready = 2'($urandom_range(0, 3));
      core_hash = rnd_blk();
      if (core_reset) sq_delay = $urandom_range(0, 10);
      reset = ($urandom_range(0, 99) == 0);
      #1;
      acc = bus.req_ready & bus.req_valid;
      r = reset;
      tick();
      if (!r) pend = pend & ~acc;
    end
    reset = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
